// File: rtl/pipe_sink_pkg.sv
// pipe_sink shared types: FSM state enum and default widths.
// Imported by pipe_sink and pipe_sink_addr_gen.
package pipe_sink_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_ADDR_WIDTH  = 4;
    localparam int DEF_FILTER_BITS = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_sink_addr_gen.sv
// pipe_sink word/filter counters with wrap and slot-full tracking.
// word_idx saturates at max; a further non-closing beat has no slot.
module pipe_sink_addr_gen
    import pipe_sink_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int FILTER_BITS = DEF_FILTER_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   write,
    input  logic                   co_filter,
    output logic [ADDR_WIDTH-1:0]  word_idx,
    output logic [FILTER_BITS-1:0] filter_idx,
    output logic                   full,
    output logic                   at_max_next
);

    localparam logic [ADDR_WIDTH-1:0]  W_MAX = '1;
    localparam logic [ADDR_WIDTH-1:0]  W_ONE = 1;
    localparam logic [FILTER_BITS-1:0] F_ONE = 1;

    logic [ADDR_WIDTH-1:0]  word_next;
    logic [FILTER_BITS-1:0] filt_next;
    logic                   full_next;

    // Next counter values: clear zeroes, a write advances or wraps.
    always_comb begin
        word_next = word_idx;
        filt_next = filter_idx;
        full_next = full;
        if (clear) begin
            word_next = '0;
            filt_next = '0;
            full_next = 1'b0;
        end else if (write) begin
            if (co_filter) begin
                word_next = '0;
                filt_next = filter_idx + F_ONE;
                full_next = 1'b0;
            end else if (word_idx == W_MAX) begin
                full_next = 1'b1;
            end else begin
                word_next = word_idx + W_ONE;
            end
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_idx   <= '0;
            filter_idx <= '0;
            full       <= 1'b0;
        end else begin
            word_idx   <= word_next;
            filter_idx <= filt_next;
            full       <= full_next;
        end
    end

    assign at_max_next = (word_next == W_MAX);

endmodule

// File: rtl/pipe_sink.sv
// pipe_sink: writes pipeline beats into a filter-slotted buffer.
// Optional macro PIPE_SINK_OVF_EN adds a sticky ovf output.
module pipe_sink
    import pipe_sink_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int FILTER_BITS = DEF_FILTER_BITS
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              stall_in,
    input  logic                              done_in,
    input  logic                              co_filter,
    input  logic [DATA_WIDTH-1:0]             in,
    input  logic                              clear,
`ifdef PIPE_SINK_OVF_EN
    output logic                              ovf,
`endif
    output logic                              wr_en,
    output logic [FILTER_BITS+ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]             wr_data,
    output logic [FILTER_BITS-1:0]            filter_idx,
    output logic                              stall_req,
    output logic                              done_out
);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  full;
    logic                  at_max_next;
    logic                  valid;
    logic                  live;
    logic                  drop;
    logic                  write;

    assign valid = !stall_in && !clear;
    assign live  = valid && (state != DONE);
    assign drop  = live && full && !co_filter;
    assign write = live && !(full && !co_filter);

    pipe_sink_addr_gen #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .FILTER_BITS (FILTER_BITS)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .write       (write),
        .co_filter   (co_filter),
        .word_idx    (word_idx),
        .filter_idx  (filter_idx),
        .full        (full),
        .at_max_next (at_max_next)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: written beats move forward, clear always returns to IDLE.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (write) begin
                    state_next = done_in ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (write && done_in) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (clear) begin
            state_next = IDLE;
        end
    end

    // Registered write port and backpressure, one cycle after the beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            stall_req <= 1'b0;
        end else begin
            wr_en     <= write;
            stall_req <= at_max_next;
            if (write) begin
                wr_addr <= {filter_idx, word_idx};
                wr_data <= in;
            end
        end
    end

    assign done_out = (state == DONE);

`ifdef PIPE_SINK_OVF_EN
    // Sticky overflow flag, set when a beat finds no free slot.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_pipe_sink.sv
// Self-checking bench for pipe_sink with a high-level slot model.
// Build with PIPE_SINK_OVF_EN to also check the ovf flag.
module tb_pipe_sink;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int FB    = 2;
    localparam int WORDS = 1 << AW;
    localparam int SLOTS = 1 << FB;

    logic          clk;
    logic          rst;
    logic          stall_in;
    logic          done_in;
    logic          co_filter;
    logic [DW-1:0] in;
    logic          clear;
    logic          wr_en;
    logic [FB+AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [FB-1:0] filter_idx;
    logic          stall_req;
    logic          done_out;
`ifdef PIPE_SINK_OVF_EN
    logic          ovf;
`endif

    int checks;
    int errors;

    // reference model: words written in current slot, slot, finished
    int            m_count;
    int            m_filter;
    bit            m_done;
    bit            m_ovf;
    bit            exp_wr;
    logic [FB+AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;

    pipe_sink #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .FILTER_BITS (FB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_in   (stall_in),
        .done_in    (done_in),
        .co_filter  (co_filter),
        .in         (in),
        .clear      (clear),
`ifdef PIPE_SINK_OVF_EN
        .ovf        (ovf),
`endif
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .filter_idx (filter_idx),
        .stall_req  (stall_req),
        .done_out   (done_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_count  = 0;
        m_filter = 0;
        m_done   = 0;
        m_ovf    = 0;
        exp_wr   = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall_in = 1'b1;
        done_in = 1'b0;
        co_filter = 1'b0;
        clear = 1'b0;
        in = '0;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    task automatic beat(input bit s, input bit dn, input bit co,
                        input logic [DW-1:0] d, input bit clr);
        int wi;
        stall_in = s;
        done_in = dn;
        co_filter = co;
        in = d;
        clear = clr;
        @(posedge clk);
        exp_wr = 0;
        if (clr) begin
            model_reset();
        end else if (!s && !m_done) begin
            if (m_count == WORDS && !co) begin
                m_ovf = 1;
            end else begin
                wi = (m_count > WORDS - 1) ? WORDS - 1 : m_count;
                exp_wr = 1;
                exp_addr = (FB+AW)'(m_filter * WORDS + wi);
                exp_data = d;
                if (co) begin
                    m_count = 0;
                    m_filter = (m_filter + 1) % SLOTS;
                end else begin
                    m_count++;
                end
                if (dn) m_done = 1;
            end
        end
        #1;
        stall_in = 1'b1;
        done_in = 1'b0;
        co_filter = 1'b0;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (wr_en !== 1'b0) begin
            errors++; $display("FAIL reset_wr_en got %0b exp 0", wr_en);
        end
        checks++;
        if (wr_addr !== '0 || wr_data !== '0) begin
            errors++; $display("FAIL reset_wr got %0h/%0h exp 0/0", wr_addr, wr_data);
        end
        checks++;
        if (filter_idx !== '0) begin
            errors++; $display("FAIL reset_filter got %0d exp 0", filter_idx);
        end
        checks++;
        if (stall_req !== 1'b0 || done_out !== 1'b0) begin
            errors++; $display("FAIL reset_flags got %0b%0b exp 00", stall_req, done_out);
        end
`ifdef PIPE_SINK_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++; $display("FAIL reset_ovf got %0b exp 0", ovf);
        end
`endif
    endtask

    task automatic test_basic();
        logic [DW-1:0] dv [3];
        dv = '{8'h11, 8'h22, 8'h33};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            beat(0, 0, 0, dv[i], 0);
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== 6'(i) || wr_data !== dv[i]) begin
                errors++;
                $display("FAIL basic_%0d got en=%0b a=%0d d=%0h exp en=1 a=%0d d=%0h",
                         i, wr_en, wr_addr, wr_data, i, dv[i]);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (wr_en !== 1'b0) begin
            errors++; $display("FAIL basic_idle got %0b exp 0", wr_en);
        end
    endtask

    task automatic test_co_filter();
        do_reset();
        beat(0, 0, 0, 8'h01, 0);
        beat(0, 0, 0, 8'h02, 0);
        beat(0, 0, 1, 8'hAA, 0);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 6'd2 || wr_data !== 8'hAA) begin
            errors++;
            $display("FAIL co_last got en=%0b a=%0d d=%0h exp 1/2/aa", wr_en, wr_addr, wr_data);
        end
        checks++;
        if (filter_idx !== 2'd1) begin
            errors++; $display("FAIL co_filter_idx got %0d exp 1", filter_idx);
        end
        beat(0, 0, 0, 8'h55, 0);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 6'd16) begin
            errors++; $display("FAIL co_next got en=%0b a=%0d exp 1/16", wr_en, wr_addr);
        end
    endtask

    task automatic test_bubbles();
        bit st [4];
        int nw;
        logic [FB+AW-1:0] a [2];
        st = '{1, 0, 1, 0};
        nw = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            beat(st[i], 0, 0, 8'(i + 8'h40), 0);
            if (wr_en === 1'b1) begin
                if (nw < 2) a[nw] = wr_addr;
                nw++;
            end
        end
        checks++;
        if (nw !== 2) begin
            errors++; $display("FAIL bubbles_count got %0d exp 2", nw);
        end else begin
            checks++;
            if (a[0] !== 6'd0 || a[1] !== 6'd1) begin
                errors++; $display("FAIL bubbles_addr got %0d,%0d exp 0,1", a[0], a[1]);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            beat(0, 0, 0, 8'(i), 0);
            if (i == 13) begin
                checks++;
                if (stall_req !== 1'b0) begin
                    errors++; $display("FAIL ovf_early_stall got %0b exp 0", stall_req);
                end
            end
        end
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 6'd15 || stall_req !== 1'b1) begin
            errors++;
            $display("FAIL ovf_16th got en=%0b a=%0d stall=%0b exp 1/15/1",
                     wr_en, wr_addr, stall_req);
        end
        beat(0, 0, 0, 8'hEE, 0);
        checks++;
        if (wr_en !== 1'b0 || stall_req !== 1'b1) begin
            errors++; $display("FAIL ovf_drop got en=%0b stall=%0b exp 0/1", wr_en, stall_req);
        end
`ifdef PIPE_SINK_OVF_EN
        checks++;
        if (ovf !== 1'b1) begin
            errors++; $display("FAIL ovf_set got %0b exp 1", ovf);
        end
`endif
        beat(0, 0, 0, 8'h00, 1);
        checks++;
        if (stall_req !== 1'b0) begin
            errors++; $display("FAIL ovf_clear_stall got %0b exp 0", stall_req);
        end
`ifdef PIPE_SINK_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_clear got %0b exp 0", ovf);
        end
`endif
    endtask

    task automatic test_done();
        do_reset();
        for (int i = 0; i < 5; i++) beat(0, (i == 4), 0, 8'(8'h60 + i), 0);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 6'd4 || done_out !== 1'b1) begin
            errors++;
            $display("FAIL done_beat got en=%0b a=%0d done=%0b exp 1/4/1",
                     wr_en, wr_addr, done_out);
        end
        for (int i = 0; i < 3; i++) begin
            beat(0, 0, 0, 8'h99, 0);
            checks++;
            if (wr_en !== 1'b0 || done_out !== 1'b1) begin
                errors++;
                $display("FAIL done_hold_%0d got en=%0b done=%0b exp 0/1", i, wr_en, done_out);
            end
        end
        beat(0, 0, 0, 8'h00, 1);
        checks++;
        if (wr_en !== 1'b0 || done_out !== 1'b0) begin
            errors++; $display("FAIL done_clear got en=%0b done=%0b exp 0/0", wr_en, done_out);
        end
        beat(0, 0, 0, 8'h5A, 0);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 6'd0) begin
            errors++; $display("FAIL done_restart got en=%0b a=%0d exp 1/0", wr_en, wr_addr);
        end
    endtask

    task automatic test_clear_midrun();
        do_reset();
        beat(0, 0, 0, 8'h01, 0);
        beat(0, 0, 1, 8'h02, 0);
        beat(0, 0, 0, 8'h03, 0);
        beat(0, 0, 0, 8'h77, 1);
        checks++;
        if (wr_en !== 1'b0 || filter_idx !== 2'd0 || done_out !== 1'b0) begin
            errors++;
            $display("FAIL clear_mid got en=%0b f=%0d done=%0b exp 0/0/0",
                     wr_en, filter_idx, done_out);
        end
        beat(0, 0, 0, 8'h78, 0);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 6'd0 || wr_data !== 8'h78) begin
            errors++;
            $display("FAIL clear_restart got en=%0b a=%0d d=%0h exp 1/0/78",
                     wr_en, wr_addr, wr_data);
        end
    endtask

    task automatic test_rst_midrun();
        do_reset();
        beat(0, 0, 1, 8'h10, 0);
        stall_in = 1'b0;
        in = 8'h20;
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
        stall_in = 1'b1;
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== '0 || filter_idx !== '0) begin
            errors++;
            $display("FAIL rst_mid got en=%0b a=%0d f=%0d exp 0/0/0",
                     wr_en, wr_addr, filter_idx);
        end
    endtask

    task automatic test_random();
        bit s, dn, co, clr;
        logic [DW-1:0] d;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            s   = ($urandom_range(0, 9) < 3);
            co  = ($urandom_range(0, 39) == 0);
            dn  = ($urandom_range(0, 99) == 0);
            clr = ($urandom_range(0, 69) == 0);
            d   = DW'($urandom);
            beat(s, dn, co, d, clr);
            checks++;
            if (wr_en !== exp_wr) begin
                errors++; $display("FAIL rnd_wr_en[%0d] got %0b exp %0b", i, wr_en, exp_wr);
            end
            if (exp_wr) begin
                checks++;
                if (wr_addr !== exp_addr || wr_data !== exp_data) begin
                    errors++;
                    $display("FAIL rnd_wr[%0d] got a=%0d d=%0h exp a=%0d d=%0h",
                             i, wr_addr, wr_data, exp_addr, exp_data);
                end
            end
            checks++;
            if (filter_idx !== FB'(m_filter)) begin
                errors++; $display("FAIL rnd_filter[%0d] got %0d exp %0d", i, filter_idx, m_filter);
            end
            checks++;
            if (stall_req !== (m_count >= WORDS - 1)) begin
                errors++; $display("FAIL rnd_stall[%0d] got %0b exp %0b",
                                   i, stall_req, (m_count >= WORDS - 1));
            end
            checks++;
            if (done_out !== m_done) begin
                errors++; $display("FAIL rnd_done[%0d] got %0b exp %0b", i, done_out, m_done);
            end
`ifdef PIPE_SINK_OVF_EN
            checks++;
            if (ovf !== m_ovf) begin
                errors++; $display("FAIL rnd_ovf[%0d] got %0b exp %0b", i, ovf, m_ovf);
            end
`endif
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_co_filter();
        test_bubbles();
        test_overflow();
        test_done();
        test_clear_midrun();
        test_rst_midrun();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
